// File: rtl/cim_vector_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : cim_vector_host_driver
// Description : Host-side sequencer for the compute-in-SRAM MAC array.
//               Streams W/A operand pairs into the array lanes. Issues a
//               single READ_S and then captures the three serialized result
//               bytes. Presents the 19-bit dot product on a valid/ready port.
// Options     : CIM_LANE_MASK_EN adds a per-lane enable mask that is sampled
//               at start. Masked lanes are loaded with W=0 and consume no
//               stream bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module cim_vector_host_driver #(
    parameter int LANES  = 8,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
`ifdef CIM_LANE_MASK_EN
    input  logic [LANES-1:0] lane_mask,
`endif
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [18:0]      res_data,
    output logic [1:0]       cim_op,
    output logic [5:0]       cim_addr,
    output logic [7:0]       cim_data,
    input  logic [7:0]       cim_rdata
);

    localparam logic [1:0] c_OP_LOAD_W = 2'b00;
    localparam logic [1:0] c_OP_LOAD_A = 2'b01;
    localparam logic [1:0] c_OP_READ_S = 2'b10;
    localparam logic [1:0] c_OP_NOP    = 2'b11;

    localparam logic [2:0] c_LAST_LANE = 3'(LANES - 1);

    // The wait counter counts down from RD_LAT-1 to 0. When it reaches 0,
    // the high byte arrives on the following cycle.
    localparam int               c_CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_INIT = c_CNT_W'(RD_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_W = 4'd1,
        S_LOAD_A = 4'd2,
        S_READ   = 4'd3,
        S_WAIT   = 4'd4,
        S_CAP2   = 4'd5,
        S_CAP1   = 4'd6,
        S_CAP0   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_lane;
    logic [2:0]           w_lane_nxt;
    logic [c_CNT_W-1:0]   r_wait_cnt;

    logic [2:0]           r_hi;
    logic [7:0]           r_mid;
    logic                 r_res_valid;
    logic [18:0]          r_res_data;

    logic [1:0]           r_cim_op;
    logic [5:0]           r_cim_addr;
    logic [7:0]           r_cim_data;

    logic                 w_issue;
    logic [1:0]           w_issue_op;
    logic [7:0]           w_issue_data;
    logic                 w_op_ready;
    logic                 w_wait_load;
    logic                 w_wait_dec;
    logic                 w_cap_hi;
    logic                 w_cap_mid;
    logic                 w_res_set;
    logic                 w_res_clr;
    logic                 w_lane_on;
    logic                 w_last_lane;

`ifdef CIM_LANE_MASK_EN
    logic [7:0]           r_mask;

    // Capture the lane mask together with an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_mask <= 8'(lane_mask);
        end
    end

    assign w_lane_on = r_mask[r_lane];
`else
    assign w_lane_on = 1'b1;
`endif

    assign w_last_lane = (r_lane == c_LAST_LANE);

    // State and lane index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lane  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_lane  <= w_lane_nxt;
        end
    end

    // Next-state decode. This block also decides which array op is
    // launched next cycle and which capture and result strobes fire.
    always_comb begin
        w_state_nxt  = r_state;
        w_lane_nxt   = r_lane;
        w_op_ready   = 1'b0;
        w_issue      = 1'b0;
        w_issue_op   = c_OP_NOP;
        w_issue_data = r_cim_data;
        w_wait_load  = 1'b0;
        w_wait_dec   = 1'b0;
        w_cap_hi     = 1'b0;
        w_cap_mid    = 1'b0;
        w_res_set    = 1'b0;
        w_res_clr    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD_W;
                    w_lane_nxt  = 3'd0;
                end
            end

            S_LOAD_W: begin
                if (!w_lane_on) begin
                    // A disabled lane still gets W cleared, so any stale
                    // weight from an earlier run contributes nothing.
                    w_issue      = 1'b1;
                    w_issue_op   = c_OP_LOAD_W;
                    w_issue_data = 8'd0;
                    if (w_last_lane) begin
                        w_state_nxt = S_READ;
                    end else begin
                        w_lane_nxt = r_lane + 3'd1;
                    end
                end else begin
                    w_op_ready = 1'b1;
                    if (op_valid) begin
                        w_issue      = 1'b1;
                        w_issue_op   = c_OP_LOAD_W;
                        w_issue_data = op_data;
                        w_state_nxt  = S_LOAD_A;
                    end
                end
            end

            S_LOAD_A: begin
                w_op_ready = 1'b1;
                if (op_valid) begin
                    w_issue      = 1'b1;
                    w_issue_op   = c_OP_LOAD_A;
                    w_issue_data = op_data;
                    if (w_last_lane) begin
                        w_state_nxt = S_READ;
                    end else begin
                        w_lane_nxt  = r_lane + 3'd1;
                        w_state_nxt = S_LOAD_W;
                    end
                end
            end

            S_READ: begin
                w_issue     = 1'b1;
                w_issue_op  = c_OP_READ_S;
                w_wait_load = 1'b1;
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = S_CAP2;
                end else begin
                    w_wait_dec = 1'b1;
                end
            end

            S_CAP2: begin
                w_cap_hi    = 1'b1;
                w_state_nxt = S_CAP1;
            end

            S_CAP1: begin
                w_cap_mid   = 1'b1;
                w_state_nxt = S_CAP0;
            end

            S_CAP0: begin
                w_res_set   = 1'b1;
                w_state_nxt = S_DONE;
            end

            S_DONE: begin
                if (res_ready) begin
                    w_res_clr   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered array bus. A launched op is visible for exactly one
    // cycle; every other cycle carries NOP, and addr/data hold their values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cim_op   <= c_OP_NOP;
            r_cim_addr <= 6'd0;
            r_cim_data <= 8'd0;
        end else begin
            r_cim_op <= w_issue ? w_issue_op : c_OP_NOP;
            if (w_issue) begin
                r_cim_addr <= {3'b000, r_lane};
                r_cim_data <= w_issue_data;
            end
        end
    end

    // Read-latency countdown between READ_S and the high byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_wait_load) begin
            r_wait_cnt <= c_WAIT_INIT;
        end else if (w_wait_dec) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    // Byte capture and result assembly. hi[7:3] is always zero for legal
    // sums, so only hi[2:0] is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi        <= 3'd0;
            r_mid       <= 8'd0;
            r_res_valid <= 1'b0;
            r_res_data  <= 19'd0;
        end else begin
            if (w_cap_hi) begin
                r_hi <= cim_rdata[2:0];
            end
            if (w_cap_mid) begin
                r_mid <= cim_rdata;
            end
            if (w_res_set) begin
                r_res_data  <= {r_hi, r_mid, cim_rdata};
                r_res_valid <= 1'b1;
            end else if (w_res_clr) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign op_ready  = w_op_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign cim_op    = r_cim_op;
    assign cim_addr  = r_cim_addr;
    assign cim_data  = r_cim_data;

endmodule
`default_nettype wire

// File: tb/tb_cim_vector_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_cim_vector_host_driver
// Description : Self-checking bench for cim_vector_host_driver. It contains a
//               behavioural MAC array and an op-trace monitor. Expected
//               results are the arithmetic dot product of the bytes streamed
//               into the driver. The lane mask test runs only when
//               CIM_LANE_MASK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cim_vector_host_driver;

    localparam int LANES  = 8;
    localparam int RD_LAT = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_data;
    logic        res_valid;
    logic        res_ready;
    logic [18:0] res_data;
    logic [1:0]  cim_op;
    logic [5:0]  cim_addr;
    logic [7:0]  cim_data;
    logic [7:0]  cim_rdata;
    logic [7:0]  lane_mask;

    cim_vector_host_driver #(
        .LANES  (LANES),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
`ifdef CIM_LANE_MASK_EN
        .lane_mask (lane_mask),
`endif
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_data   (op_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .cim_op    (cim_op),
        .cim_addr  (cim_addr),
        .cim_data  (cim_data),
        .cim_rdata (cim_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural MAC array: stores loads and, after READ_S, serializes
    // the sum as hi/mid/lo. The high byte carries random upper bits, and
    // idle cycles carry random junk.
    // ------------------------------------------------------------------
    logic [7:0]  arr_w [8];
    logic [7:0]  arr_a [8];
    int          rd_phase;
    logic [18:0] rd_sum;

    initial begin
        for (int i = 0; i < 8; i++) begin
            arr_w[i] = 8'd0;
            arr_a[i] = 8'd0;
        end
        rd_phase = 0;
        rd_sum   = '0;
    end

    function automatic logic [18:0] array_sum();
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) s += int'(arr_w[i]) * int'(arr_a[i]);
        return 19'(s);
    endfunction

    always @(posedge clk) begin
        if (cim_op == 2'b00) arr_w[cim_addr[2:0]] <= cim_data;
        if (cim_op == 2'b01) arr_a[cim_addr[2:0]] <= cim_data;
        if (cim_op == 2'b10) begin
            rd_sum    <= array_sum();
            rd_phase  <= 1;
            cim_rdata <= 8'($urandom);
        end else if (rd_phase != 0) begin
            if (rd_phase == RD_LAT - 1)      cim_rdata <= {5'($urandom), rd_sum[18:16]};
            else if (rd_phase == RD_LAT)     cim_rdata <= rd_sum[15:8];
            else if (rd_phase == RD_LAT + 1) cim_rdata <= rd_sum[7:0];
            else                             cim_rdata <= 8'($urandom);
            rd_phase <= (rd_phase == RD_LAT + 1) ? 0 : rd_phase + 1;
        end else begin
            cim_rdata <= 8'($urandom);
        end
    end

    // ------------------------------------------------------------------
    // Op-trace monitor: logs every non-NOP array op along with its cycle.
    // ------------------------------------------------------------------
    typedef struct {
        int         cyc;
        logic [1:0] op;
        logic [5:0] addr;
        logic [7:0] data;
    } tr_t;

    tr_t trace[$];
    int  cyc_cnt = 0;

    always @(negedge clk) begin
        tr_t t;
        cyc_cnt++;
        if (cim_op !== 2'b11) begin
            t.cyc  = cyc_cnt;
            t.op   = cim_op;
            t.addr = cim_addr;
            t.data = cim_data;
            trace.push_back(t);
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] cur_w [8];
    logic [7:0] cur_a [8];
    logic [7:0] cur_mask;
    int         last_res;

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        op_valid = 1'b1;
        op_data  = b;
        while (!op_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("op_ready_wait", 32'(op_ready), 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic run_vec(input int stall_lane, input int stall_n,
                           input int ready_delay, input bit start_in_done);
        int base;
        int exp_sum;
        int exp_n;
        int idx;
        int t;
        exp_sum = 0;
        exp_n   = 1;
        for (int i = 0; i < LANES; i++) begin
            if (cur_mask[i]) begin
                exp_sum += int'(cur_w[i]) * int'(cur_a[i]);
                exp_n   += 2;
            end else begin
                exp_n   += 1;
            end
        end
        base = trace.size();
        lane_mask = cur_mask;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);

        for (int i = 0; i < LANES; i++) begin
            if (cur_mask[i]) begin
                if (i == stall_lane) repeat (stall_n) @(negedge clk);
                send_byte(cur_w[i]);
                send_byte(cur_a[i]);
            end
        end

        t = 0;
        while (!res_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("res_valid_rise", 32'(res_valid), 32'd1);
        chk("res_data", 32'(res_data), 32'(exp_sum));
        last_res = int'(res_data);

        chk("op_count", 32'(trace.size() - base), 32'(exp_n));
        idx = base;
        for (int i = 0; i < LANES; i++) begin
            if (cur_mask[i]) begin
                chk("op_load_w", {16'd0, trace[idx].op, trace[idx].addr, trace[idx].data},
                    {16'd0, 2'b00, 6'(i), cur_w[i]});
                chk("op_load_a", {16'd0, trace[idx+1].op, trace[idx+1].addr, trace[idx+1].data},
                    {16'd0, 2'b01, 6'(i), cur_a[i]});
                idx += 2;
            end else begin
                chk("op_mask_w", {16'd0, trace[idx].op, trace[idx].addr, trace[idx].data},
                    {16'd0, 2'b00, 6'(i), 8'd0});
                idx += 1;
            end
        end
        chk("op_read", 32'(trace[idx].op), 32'd2);
        chk("read_gap", 32'(trace[idx].cyc - trace[idx-1].cyc), 32'd1);
        if (stall_n > 0 && cur_mask == 8'hFF) begin
            chk("stall_gap", 32'(trace[base+2*stall_lane].cyc - trace[base+2*stall_lane-1].cyc),
                32'(stall_n + 1));
        end

        for (int k = 0; k < ready_delay; k++) begin
            start = (start_in_done && k == 1);
            @(negedge clk);
            chk("done_hold_valid", 32'(res_valid), 32'd1);
            chk("done_hold_data", 32'(res_data), 32'(exp_sum));
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("valid_cleared", 32'(res_valid), 32'd0);
        chk("idle_after_hs", 32'(busy), 32'd0);
        chk("data_retained", 32'(res_data), 32'(exp_sum));
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_cim_op", 32'(cim_op), 32'd3);
        chk("rst_cim_addr", 32'(cim_addr), 32'd0);
        chk("rst_cim_data", 32'(cim_data), 32'd0);
    endtask

    // Watchdog: end the run if a DUT wait ever escapes its bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int saved;
        rst       = 1'b1;
        start     = 1'b0;
        op_valid  = 1'b0;
        op_data   = 8'd0;
        res_ready = 1'b0;
        cur_mask  = 8'hFF;
        lane_mask = 8'hFF;
        last_res  = 0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // W = 1..8 and A = 1 give 36.
        for (int i = 0; i < 8; i++) begin
            cur_w[i] = 8'(i + 1);
            cur_a[i] = 8'd1;
        end
        run_vec(0, 0, 2, 1'b0);

        // All bytes 0xFF produce the maximum sum 0x7F008.
        for (int i = 0; i < 8; i++) begin
            cur_w[i] = 8'hFF;
            cur_a[i] = 8'hFF;
        end
        run_vec(0, 0, 1, 1'b0);
        chk("max_sum", 32'(res_data), 32'h7F008);

        // Random data, first with no stall, then with a 3-cycle stall before W4.
        for (int i = 0; i < 8; i++) begin
            cur_w[i] = 8'($urandom);
            cur_a[i] = 8'($urandom);
        end
        run_vec(0, 0, 0, 1'b0);
        saved = last_res;
        run_vec(4, 3, 0, 1'b0);
        chk("stall_same_result", 32'(last_res), 32'(saved));

        // Hold res_ready low for 5 cycles and pulse start during DONE.
        run_vec(0, 0, 5, 1'b1);

        // Reset while in LOAD_A for lane 5.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'd9);
            send_byte(8'd9);
        end
        send_byte(8'd9);
        chk("in_load_a_ready", 32'(op_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals();

        // W = 2 and A = 3 on all lanes give 48.
        for (int i = 0; i < 8; i++) begin
            cur_w[i] = 8'd2;
            cur_a[i] = 8'd3;
        end
        run_vec(0, 0, 1, 1'b0);

        // Random vectors with random stalls and random result back-pressure.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) begin
                cur_w[i] = 8'($urandom);
                cur_a[i] = 8'($urandom);
            end
            run_vec(int'($urandom_range(1, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)), 1'b0);
        end

`ifdef CIM_LANE_MASK_EN
        // Only lanes 0 and 2 are enabled: 10*10 + 20*3 = 160.
        for (int i = 0; i < 8; i++) begin
            cur_w[i] = 8'd0;
            cur_a[i] = 8'd0;
        end
        cur_w[0] = 8'd10;
        cur_a[0] = 8'd10;
        cur_w[2] = 8'd20;
        cur_a[2] = 8'd3;
        cur_mask = 8'b0000_0101;
        run_vec(0, 0, 1, 1'b0);
        chk("mask_sum", 32'(last_res), 32'd160);

        // An all-zero mask gives a zero result.
        cur_mask = 8'h00;
        run_vec(0, 0, 1, 1'b0);
        cur_mask = 8'hFF;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
